// File: rtl/switch_case_sched_pkg.sv
// ----------------------------------------------------------------------------
// switch_case_sched_pkg
//   Shared definitions for the switch_case_sched block: the scheduler FSM
//   state type, the lookup result constants, and a small modular-increment
//   helper used by the round-robin picker.
// ----------------------------------------------------------------------------
package switch_case_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      GRANT = 2'd1,
      RESP  = 2'd2
   } state_t;

   // Lookup results selected by the latched case selector
   localparam logic [1:0] VAL_SEL0 = 2'h1;
   localparam logic [1:0] VAL_SEL1 = 2'h3;
   localparam logic [2:0] NUM_SEL0 = 3'h2;
   localparam logic [2:0] NUM_SEL1 = 3'h4;

   // (a + b) mod n, valid when a < n and b < n
   function automatic int unsigned wrap_add(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned n);
      int unsigned s;
      s = a + b;
      return (s >= n) ? (s - n) : s;
   endfunction

endpackage

// File: rtl/switch_case_sched_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
//   Purely combinational round-robin picker. Searches i_req starting at
//   index i_ptr and wrapping, returning the first requester found.
//   Ports:
//     i_req    - request vector, one bit per requester
//     i_ptr    - index at which the search starts (must be < N_REQ)
//     o_onehot - one-hot of the winner, 0 when no request
//     o_idx    - index of the winner, 0 when no request
// ----------------------------------------------------------------------------
module rr_pick
   import switch_case_sched_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int ID_W  = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [ID_W-1:0]  i_ptr,
   output logic [N_REQ-1:0] o_onehot,
   output logic [ID_W-1:0]  o_idx
);

   localparam int unsigned NR = N_REQ;

   logic w_found;

   // Priority order k = 0..NR-1 visits requester (ptr + k) mod NR; the
   // inner loop matches that position against each physical index so no
   // variable bit-select is needed.
   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      w_found  = 1'b0;
      for (int unsigned k = 0; k < NR; k++) begin
         for (int unsigned i = 0; i < NR; i++) begin
            if (!w_found && i_req[i] &&
                (i == wrap_add(32'(i_ptr), k, NR))) begin
               w_found     = 1'b1;
               o_onehot[i] = 1'b1;
               o_idx       = ID_W'(i);
            end
         end
      end
   end

endmodule

// File: rtl/switch_case_sched.sv
// ----------------------------------------------------------------------------
// switch_case_sched
//   Round-robin scheduler that grants one requester at a time, latches that
//   requester's 1-bit case selector, and presents a looked-up result until
//   the downstream accepts it.
//   Ports:
//     clk       - clock, rising edge
//     rst       - asynchronous active-low reset
//     req       - per-requester request (level)
//     code      - per-requester case selector, sampled for the granted one
//     gnt       - registered one-hot grant, high for one cycle per service
//     out_valid - result valid (RESP state)
//     out_ready - downstream accept
//     out_val   - 2-bit lookup result
//     out_num   - 3-bit lookup result
//     out_id    - index of the served requester (held outside RESP)
//     busy      - FSM not idle
// ----------------------------------------------------------------------------
module switch_case_sched
   import switch_case_sched_pkg::*;
#(
   parameter int N_REQ = 3,
   parameter int ID_W  = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] code,
   output logic [N_REQ-1:0] gnt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       out_val,
   output logic [2:0]       out_num,
   output logic [ID_W-1:0]  out_id,
   output logic             busy
);

   state_t           r_state;
   state_t           w_next;
   logic [ID_W-1:0]  r_ptr;
   logic [ID_W-1:0]  r_id;
   logic [ID_W-1:0]  r_out_id;
   logic             r_sel;
   logic [N_REQ-1:0] r_gnt;

   logic [N_REQ-1:0] w_pick_onehot;
   logic [ID_W-1:0]  w_pick_idx;
   logic             w_code_bit;
   logic [1:0]       w_lk_val;
   logic [2:0]       w_lk_num;

   rr_pick #(
      .N_REQ (N_REQ),
      .ID_W  (ID_W)
   ) u_rr_pick (
      .i_req    (req),
      .i_ptr    (r_ptr),
      .o_onehot (w_pick_onehot),
      .o_idx    (w_pick_idx)
   );

   // code[r_id] selected by compare so the index width never has to match
   always_comb begin
      w_code_bit = 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) begin
         if (ID_W'(i) == r_id) w_code_bit = code[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= IDLE;
      else      r_state <= w_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ptr    <= '0;
         r_id     <= '0;
         r_out_id <= '0;
         r_sel    <= 1'b0;
         r_gnt    <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (|req) begin
                  r_gnt <= w_pick_onehot;
                  r_id  <= w_pick_idx;
               end
            end
            GRANT: begin
               r_sel    <= w_code_bit;
               r_gnt    <= '0;
               r_out_id <= r_id;
            end
            RESP: begin
               if (out_ready)
                  r_ptr <= (r_id == ID_W'(N_REQ - 1)) ? '0 : r_id + 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next    = r_state;
      out_valid = 1'b0;
      out_val   = '0;
      out_num   = '0;
      busy      = (r_state != IDLE);
      w_lk_val  = '0;
      w_lk_num  = '0;

      case (r_sel)
         1'b0: begin
            w_lk_val = VAL_SEL0;
            w_lk_num = NUM_SEL0;
         end
         1'b1: begin
            w_lk_val = VAL_SEL1;
            w_lk_num = NUM_SEL1;
         end
         default: begin
            w_lk_val = 2'h0;
            w_lk_num = 3'h0;
         end
      endcase

      case (r_state)
         IDLE:  if (|req) w_next = GRANT;
         GRANT: w_next = RESP;
         RESP: begin
            out_valid = 1'b1;
            out_val   = w_lk_val;
            out_num   = w_lk_num;
            if (out_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   assign gnt    = r_gnt;
   assign out_id = r_out_id;

endmodule
